// File: rtl/adc_capture_ctrl.sv
// ADC capture-window controller: it discards settling samples, box-car averages
// groups of 1/2/4/8 codes, and writes a fixed number of words into the ADC code FIFO.
module adc_capture_ctrl #(
  parameter int PRECISION = 10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PRECISION-1:0] adc_code_in,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           settle_count,
  input  logic [CNT_WIDTH-1:0] sample_count,
  input  logic [1:0]           avg_log2,
  input  logic                 fifo_full,
  output logic [PRECISION-1:0] fifo_din,
  output logic                 fifo_wr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] words_written
);

  localparam int ACC_W = PRECISION + 3;

  typedef enum logic [1:0] {IDLE, SETTLE, ACQUIRE} state_t;

  state_t               state;
  logic [7:0]           settle_cnt;
  logic [CNT_WIDTH-1:0] n_lat;
  logic [CNT_WIDTH-1:0] word_cnt;
  logic [1:0]           g_lat;
  logic [ACC_W-1:0]     acc;
  logic [2:0]           grp_cnt;

  logic [ACC_W-1:0]     sum;
  logic [2:0]           grp_last;
  logic [CNT_WIDTH-1:0] word_cnt_nxt;

  // Three guard bits let eight full-scale codes sum without wrapping.
  assign sum          = acc + ACC_W'(adc_code_in);
  assign grp_last     = 3'((4'd1 << g_lat) - 4'd1);
  assign word_cnt_nxt = word_cnt + CNT_WIDTH'(1);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      n_lat         <= '0;
      word_cnt      <= '0;
      g_lat         <= '0;
      acc           <= '0;
      grp_cnt       <= '0;
      fifo_din      <= '0;
      fifo_wr_en    <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      words_written <= '0;
    end else begin
      // NOTE: the strobe defaults low every edge so it can never stretch past one cycle.
      fifo_wr_en <= 1'b0;
      if (abort) begin
        // Abort beats start and drops any partial group; the sticky status holds.
        state   <= IDLE;
        acc     <= '0;
        grp_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              settle_cnt    <= settle_count;
              n_lat         <= sample_count;
              g_lat         <= avg_log2;
              acc           <= '0;
              grp_cnt       <= '0;
              word_cnt      <= '0;
              done          <= 1'b0;
              overflow      <= 1'b0;
              words_written <= '0;
              state         <= (settle_count != 8'd0) ? SETTLE : ACQUIRE;
            end
          end
          SETTLE: begin
            settle_cnt <= settle_cnt - 8'd1;
            if (settle_cnt == 8'd1) state <= ACQUIRE;
          end
          ACQUIRE: begin
            if (grp_cnt == grp_last) begin
              fifo_din <= PRECISION'(sum >> g_lat);
              acc      <= '0;
              grp_cnt  <= '0;
              word_cnt <= word_cnt_nxt;
              if (fifo_full) begin
                overflow <= 1'b1;
              end else begin
                fifo_wr_en <= 1'b1;
                if (words_written != '1) words_written <= words_written + CNT_WIDTH'(1);
              end
              // A dropped word still consumes its slot, so the window is fixed in time.
              if (n_lat != '0 && word_cnt_nxt == n_lat) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end else begin
              acc     <= sum;
              grp_cnt <= grp_cnt + 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: a table of complete captures plus hand-written
// sequences for abort, start protection, counter saturation and asynchronous reset.
module tb_adc_capture_ctrl;

  localparam int P  = 10;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [P-1:0]  adc_code_in;
  logic          start, abort;
  logic [7:0]    settle_count;
  logic [CW-1:0] sample_count;
  logic [1:0]    avg_log2;
  logic          fifo_full;
  logic [P-1:0]  fifo_din;
  logic          fifo_wr_en, busy, done, overflow;
  logic [CW-1:0] words_written;

  int n_checks = 0;
  int n_fail   = 0;

  adc_capture_ctrl #(.PRECISION(P), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .adc_code_in(adc_code_in), .start(start), .abort(abort),
    .settle_count(settle_count), .sample_count(sample_count), .avg_log2(avg_log2),
    .fifo_full(fifo_full), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .busy(busy),
    .done(done), .overflow(overflow), .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {K_RAMP, K_AVG, K_FULL} kind_t;

  typedef struct packed {
    logic [7:0]        settle;
    logic [CW-1:0]     n;
    logic [1:0]        avg;
    kind_t             kind;
    logic [7:0]        full_edge;     // edge index with fifo_full=1, 0 = never
    logic [7:0]        restart_edge;  // edge index with an extra start pulse, 0 = never
    logic [7:0]        exp_n;
    logic [0:4][P-1:0] exp_word;
    logic [0:4][7:0]   exp_edge;
    logic [7:0]        exp_done;
    logic [CW-1:0]     exp_ww;
    logic              exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Code presented at edge E(i) of a capture.
  function automatic logic [P-1:0] code_at(input kind_t k, input int i);
    case (k)
      K_RAMP:  return P'(i);
      K_AVG:   return (i <= 4) ? P'(9 + i) : P'(15 + i);
      default: return P'(1023);
    endcase
  endfunction

  task automatic run_capture(input int idx, input vec_t v);
    int nw;
    int done_edge;
    nw = 0;
    done_edge = -1;
    @(negedge clk);
    settle_count = v.settle;
    sample_count = v.n;
    avg_log2     = v.avg;
    start        = 1'b1;
    fifo_full    = 1'b0;
    adc_code_in  = code_at(v.kind, 0);
    for (int e = 0; e <= 100; e++) begin
      @(negedge clk);
      if (e == 0) begin
        check($sformatf("v%0d busy_after_start", idx), 32'(busy), 1);
        check($sformatf("v%0d done_cleared", idx), 32'(done), 0);
        check($sformatf("v%0d ovf_cleared", idx), 32'(overflow), 0);
        check($sformatf("v%0d ww_cleared", idx), 32'(words_written), 0);
        // Scramble the configuration: only the latched copy may matter now.
        settle_count = 8'hff;
        sample_count = CW'(7);
        avg_log2     = ~v.avg;
      end
      if (fifo_wr_en) begin
        if (nw < 5) begin
          check($sformatf("v%0d word%0d", idx, nw), 32'(fifo_din), 32'(v.exp_word[nw]));
          check($sformatf("v%0d edge%0d", idx, nw), e, 32'(v.exp_edge[nw]));
        end
        nw++;
      end
      if (done) begin
        done_edge = e;
        break;
      end
      start       = (e + 1 == int'(v.restart_edge));
      fifo_full   = (e + 1 == int'(v.full_edge));
      adc_code_in = code_at(v.kind, e + 1);
    end
    start     = 1'b0;
    fifo_full = 1'b0;
    check($sformatf("v%0d n_writes", idx), nw, 32'(v.exp_n));
    check($sformatf("v%0d done_edge", idx), done_edge, 32'(v.exp_done));
    check($sformatf("v%0d busy_at_done", idx), 32'(busy), 0);
    check($sformatf("v%0d words_written", idx), 32'(words_written), 32'(v.exp_ww));
    check($sformatf("v%0d overflow", idx), 32'(overflow), 32'(v.exp_ovf));
  endtask

  initial begin
    int nw;
    rst_n = 1'b0; adc_code_in = '0; start = 1'b0; abort = 1'b0;
    settle_count = '0; sample_count = '0; avg_log2 = '0; fifo_full = 1'b0;

    //                settle  n      avg   kind    full   rest   exp_n  words                                  edges                                  done    ww      ovf
    vecs[0] = '{8'd3, 8'd4, 2'd0, K_RAMP, 8'd0, 8'd0, 8'd4, '{10'd4, 10'd5, 10'd6, 10'd7, 10'd0},       '{8'd4, 8'd5, 8'd6, 8'd7, 8'd0},       8'd7,  8'd4, 1'b0};
    vecs[1] = '{8'd0, 8'd2, 2'd2, K_AVG,  8'd0, 8'd0, 8'd2, '{10'd11, 10'd21, 10'd0, 10'd0, 10'd0},     '{8'd4, 8'd8, 8'd0, 8'd0, 8'd0},       8'd8,  8'd2, 1'b0};
    vecs[2] = '{8'd2, 8'd3, 2'd3, K_FULL, 8'd0, 8'd0, 8'd3, '{10'd1023, 10'd1023, 10'd1023, 10'd0, 10'd0}, '{8'd10, 8'd18, 8'd26, 8'd0, 8'd0}, 8'd26, 8'd3, 1'b0};
    vecs[3] = '{8'd0, 8'd5, 2'd0, K_RAMP, 8'd3, 8'd0, 8'd4, '{10'd1, 10'd2, 10'd4, 10'd5, 10'd0},       '{8'd1, 8'd2, 8'd4, 8'd5, 8'd0},       8'd5,  8'd4, 1'b1};
    vecs[4] = '{8'd1, 8'd3, 2'd1, K_RAMP, 8'd0, 8'd0, 8'd3, '{10'd2, 10'd4, 10'd6, 10'd0, 10'd0},       '{8'd3, 8'd5, 8'd7, 8'd0, 8'd0},       8'd7,  8'd3, 1'b0};
    vecs[5] = '{8'd0, 8'd4, 2'd0, K_RAMP, 8'd0, 8'd2, 8'd4, '{10'd1, 10'd2, 10'd3, 10'd4, 10'd0},       '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0},       8'd4,  8'd4, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst fifo_din", 32'(fifo_din), 0);
    check("rst wr_en", 32'(fifo_wr_en), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst overflow", 32'(overflow), 0);
    check("rst words_written", 32'(words_written), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy", 32'(busy), 0);

    for (int i = 0; i < 6; i++) run_capture(i, vecs[i]);

    // start together with abort in IDLE: stays idle and the previous done survives.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; settle_count = 8'd0; sample_count = CW'(2); avg_log2 = 2'd0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start+abort busy", 32'(busy), 0);
    check("start+abort done", 32'(done), 1);
    @(negedge clk);
    check("start+abort still idle", 32'(busy), 0);

    // Abort after 6 samples of a continuous G=4 capture: one word (1+2+3+4)>>2, no partial word.
    nw = 0;
    settle_count = 8'd0; sample_count = CW'(0); avg_log2 = 2'd2;
    start = 1'b1; adc_code_in = code_at(K_RAMP, 0);
    for (int e = 0; e <= 12; e++) begin
      @(negedge clk);
      if (fifo_wr_en) begin
        nw++;
        check("abort word", 32'(fifo_din), 2);
      end
      if (e == 7) begin
        check("abort busy", 32'(busy), 0);
        check("abort done", 32'(done), 0);
      end
      start       = 1'b0;
      abort       = (e + 1 == 7);
      adc_code_in = code_at(K_RAMP, e + 1);
    end
    abort = 1'b0;
    check("abort n_writes", nw, 1);
    check("abort words_written", 32'(words_written), 1);
    check("abort fifo_din held", 32'(fifo_din), 2);

    // Continuous G=1 capture past 2^CW words: words_written saturates.
    settle_count = 8'd0; sample_count = CW'(0); avg_log2 = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("sat words_written", 32'(words_written), 255);
    check("sat busy", 32'(busy), 0);
    check("sat done", 32'(done), 0);
    check("sat overflow", 32'(overflow), 0);

    // Asynchronous reset in the middle of ACQUIRE with overflow set and a write pending.
    settle_count = 8'd0; sample_count = CW'(0); avg_log2 = 2'd0; adc_code_in = P'(77);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; fifo_full = 1'b1;
    @(negedge clk);
    fifo_full = 1'b0;
    @(negedge clk);
    check("pre-reset overflow", 32'(overflow), 1);
    check("pre-reset wr_en", 32'(fifo_wr_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async fifo_din", 32'(fifo_din), 0);
    check("async wr_en", 32'(fifo_wr_en), 0);
    check("async busy", 32'(busy), 0);
    check("async done", 32'(done), 0);
    check("async overflow", 32'(overflow), 0);
    check("async words_written", 32'(words_written), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
